// File: rtl/busca_instrucao.sv
// Instruction fetch unit for an 8-bit core with a byte-wide program ROM.
// Fetches a 1- or 2-byte instruction through endereco/dado, presents it with
// a valid/ready handshake, and accepts redirects from the control unit.
// A fetch outside the populated ROM halts the unit until reset.
module busca_instrucao #(
  parameter int         TAM_ROM     = 128,
  parameter logic [7:0] VETOR_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] endereco,
  input  logic [7:0] dado,
  input  logic       desvio,
  input  logic [7:0] desvio_alvo,
  input  logic       instr_pronta,
  output logic       instr_valida,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operando,
  output logic [7:0] instr_pc,
  output logic       erro_endereco
);

  typedef enum logic [1:0] {
    BUSCA_OP   = 2'd0,
    BUSCA_OPER = 2'd1,
    ENTREGA    = 2'd2,
    PARADO     = 2'd3
  } estado_t;

  // 9-bit limit so that TAM_ROM = 256 means "every 8-bit address is valid".
  localparam logic [8:0] LIMITE = 9'(TAM_ROM);

  estado_t    estado, estado_prox;
  logic [7:0] pc, pc_prox;
  logic [7:0] opcode, opcode_prox;
  logic [7:0] operando, operando_prox;
  logic [7:0] pc_instr, pc_instr_prox;
  logic       erro, erro_prox;
  logic       fora_rom;

  // Opcodes whose high nibble is 0, 1, 3, 4 or 5 carry no operand byte.
  function automatic logic instr_um_byte(input logic [7:0] op);
    case (op[7:4])
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  assign fora_rom = ({1'b0, pc} >= LIMITE);

  // Next-state, next-PC and capture decisions; a redirect beats everything.
  always_comb begin
    estado_prox   = estado;
    pc_prox       = pc;
    opcode_prox   = opcode;
    operando_prox = operando;
    pc_instr_prox = pc_instr;
    erro_prox     = erro;
    case (estado)
      BUSCA_OP: begin
        if (desvio) begin
          pc_prox     = desvio_alvo;
          estado_prox = BUSCA_OP;
        end else if (fora_rom) begin
          erro_prox   = 1'b1;
          estado_prox = PARADO;
        end else begin
          opcode_prox   = dado;
          operando_prox = 8'h00;
          pc_instr_prox = pc;
          pc_prox       = pc + 8'd1;
          estado_prox   = instr_um_byte(dado) ? ENTREGA : BUSCA_OPER;
        end
      end
      BUSCA_OPER: begin
        if (desvio) begin
          pc_prox     = desvio_alvo;
          estado_prox = BUSCA_OP;
        end else if (fora_rom) begin
          erro_prox   = 1'b1;
          estado_prox = PARADO;
        end else begin
          operando_prox = dado;
          pc_prox       = pc + 8'd1;
          estado_prox   = ENTREGA;
        end
      end
      ENTREGA: begin
        // With desvio and instr_pronta together the handshake still counts;
        // the redirect only decides where the next fetch starts.
        if (desvio) begin
          pc_prox     = desvio_alvo;
          estado_prox = BUSCA_OP;
        end else if (instr_pronta) begin
          estado_prox = BUSCA_OP;
        end
      end
      PARADO: begin
        estado_prox = PARADO;
      end
      default: begin
        estado_prox = PARADO;
      end
    endcase
  end

  // State, PC and instruction registers; reset aborts any fetch in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= BUSCA_OP;
      pc       <= VETOR_RESET;
      opcode   <= 8'h00;
      operando <= 8'h00;
      pc_instr <= 8'h00;
      erro     <= 1'b0;
    end else begin
      estado   <= estado_prox;
      pc       <= pc_prox;
      opcode   <= opcode_prox;
      operando <= operando_prox;
      pc_instr <= pc_instr_prox;
      erro     <= erro_prox;
    end
  end

  assign endereco       = pc;
  assign instr_valida   = (estado == ENTREGA);
  assign instr_opcode   = opcode;
  assign instr_operando = operando;
  assign instr_pc       = pc_instr;
  assign erro_endereco  = erro;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed scenarios plus a randomized run checked
// against an instruction-stream walk of the ROM contents.
module tb_busca_instrucao;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       desvio = 1'b0;
  logic [7:0] alvo = 8'h00;
  logic       pronta = 1'b0;
  logic [7:0] rom [0:255];

  logic [7:0] endereco, dado, opcode, operando, ipc;
  logic       valida, erro;
  logic [7:0] endereco2, dado2, opcode2, operando2, ipc2;
  logic       valida2, erro2;

  int errors = 0;
  int checks = 0;
  int delivered = 0;

  always #5 clk = ~clk;

  assign dado  = rom[endereco];
  assign dado2 = rom[endereco2];

  busca_instrucao #(.TAM_ROM(128), .VETOR_RESET(8'h00)) u_dut (
    .clk(clk), .reset(reset), .endereco(endereco), .dado(dado),
    .desvio(desvio), .desvio_alvo(alvo), .instr_pronta(pronta),
    .instr_valida(valida), .instr_opcode(opcode), .instr_operando(operando),
    .instr_pc(ipc), .erro_endereco(erro)
  );

  // Second instance: full 256-entry ROM and non-zero reset vector, for PC wrap.
  busca_instrucao #(.TAM_ROM(256), .VETOR_RESET(8'hFE)) u_dut2 (
    .clk(clk), .reset(reset), .endereco(endereco2), .dado(dado2),
    .desvio(desvio), .desvio_alvo(alvo), .instr_pronta(pronta),
    .instr_valida(valida2), .instr_opcode(opcode2), .instr_operando(operando2),
    .instr_pc(ipc2), .erro_endereco(erro2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tem_operando(input logic [7:0] op);
    return !(op[7:4] inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5});
  endfunction

  task automatic tick();
    if (valida === 1'b1 && pronta) delivered++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_endereco", endereco, 8'h00);
    chk("rst_valida", valida, 1'b0);
    chk("rst_opcode", opcode, 8'h00);
    chk("rst_operando", operando, 8'h00);
    chk("rst_pc", ipc, 8'h00);
    chk("rst_erro", erro, 1'b0);
    chk("rst_endereco2", endereco2, 8'hFE);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] op, input logic [7:0] oper,
                           input logic [7:0] pc);
    chk({tag, "_valida"}, valida, 1'b1);
    chk({tag, "_opcode"}, opcode, op);
    chk({tag, "_operando"}, operando, oper);
    chk({tag, "_pc"}, ipc, pc);
  endtask

  initial begin
    logic [7:0] exp_pc, e_op, e_oper;
    logic [7:0] h_op, h_oper, h_pc;
    bit         hold;
    int         rnd_deliv;

    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    #2;

    // Two-byte fetch, latency 2, then hold while consumer stalls.
    rom[0] = 8'h86; rom[1] = 8'hAA; rom[2] = 8'h96; rom[3] = 8'hE0;
    rom[4] = 8'h20; rom[5] = 8'h00;
    pronta = 1'b1;
    do_reset();
    tick();
    chk("lat2_c1_valida", valida, 1'b0);
    chk("lat2_c1_endereco", endereco, 8'h01);
    tick();
    chk_instr("lat2", 8'h86, 8'hAA, 8'h00);
    chk("lat2_endereco", endereco, 8'h02);
    pronta = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_instr("hold", 8'h86, 8'hAA, 8'h00);
      chk("hold_endereco", endereco, 8'h02);
    end
    pronta = 1'b1;
    tick();
    chk("ack_valida", valida, 1'b0);
    chk("ack_endereco", endereco, 8'h02);
    tick();
    chk("f2_endereco", endereco, 8'h03);
    tick();
    chk_instr("f2", 8'h96, 8'hE0, 8'h02);
    chk("f2_endereco_after", endereco, 8'h04);
    tick();
    tick();
    chk("midfetch_endereco", endereco, 8'h05);

    // Reset in the middle of an operand fetch; then a 1-byte instruction.
    rom[0] = 8'h01;
    do_reset();
    tick();
    chk_instr("lat1", 8'h01, 8'h00, 8'h00);
    chk("lat1_endereco", endereco, 8'h01);
    rom[1] = 8'h10;
    tick();
    chk("lat1_ack_valida", valida, 1'b0);
    chk("lat1_ack_endereco", endereco, 8'h01);
    pronta = 1'b0;
    tick();
    chk_instr("lat1b", 8'h10, 8'h00, 8'h01);

    // Redirect from ENTREGA discards the undelivered instruction, then
    // a redirect during the operand fetch of opcode 20.
    desvio = 1'b1; alvo = 8'h04;
    tick();
    chk("dsv_e_valida", valida, 1'b0);
    chk("dsv_e_endereco", endereco, 8'h04);
    desvio = 1'b0;
    tick();
    chk("dsv_oper_endereco", endereco, 8'h05);
    chk("dsv_oper_valida", valida, 1'b0);
    desvio = 1'b1; alvo = 8'h10;
    tick();
    chk("dsv_o_valida", valida, 1'b0);
    chk("dsv_o_endereco", endereco, 8'h10);
    desvio = 1'b0;
    rom[8'h10] = 8'h35;
    tick();
    chk_instr("dsv_new", 8'h35, 8'h00, 8'h10);

    // Redirect together with acceptance: delivered exactly once.
    delivered = 0;
    rom[8'h20] = 8'h00;
    desvio = 1'b1; alvo = 8'h20; pronta = 1'b1;
    tick();
    chk("dsvack_count", delivered, 1);
    chk("dsvack_valida", valida, 1'b0);
    chk("dsvack_endereco", endereco, 8'h20);
    desvio = 1'b0; pronta = 1'b0;
    tick();
    chk_instr("dsvack_next", 8'h00, 8'h00, 8'h20);
    tick();
    chk("dsvack_count2", delivered, 1);

    // Opcode fetch at the ROM limit; redirect beats the range check.
    desvio = 1'b1; alvo = 8'h80;
    tick();
    chk("lim_endereco", endereco, 8'h80);
    chk("lim_erro0", erro, 1'b0);
    alvo = 8'h05;
    tick();
    chk("prio_endereco", endereco, 8'h05);
    chk("prio_erro", erro, 1'b0);
    alvo = 8'h80;
    tick();
    desvio = 1'b0;
    tick();
    chk("lim_erro", erro, 1'b1);
    chk("lim_endereco_hold", endereco, 8'h80);
    chk("lim_valida", valida, 1'b0);

    // Operand fetch runs off the end of the ROM; PARADO ignores everything.
    rom[8'h7F] = 8'h86;
    do_reset();
    pronta = 1'b1; desvio = 1'b1; alvo = 8'h7F;
    tick();
    chk("ovf_endereco", endereco, 8'h7F);
    desvio = 1'b0;
    tick();
    chk("ovf_oper_endereco", endereco, 8'h80);
    chk("ovf_oper_erro", erro, 1'b0);
    tick();
    chk("ovf_erro", erro, 1'b1);
    chk("ovf_valida", valida, 1'b0);
    desvio = 1'b1; alvo = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("parado_erro", erro, 1'b1);
      chk("parado_endereco", endereco, 8'h80);
      chk("parado_valida", valida, 1'b0);
    end
    desvio = 1'b0;
    rom[0] = 8'h01;
    do_reset();
    tick();
    chk_instr("post_err", 8'h01, 8'h00, 8'h00);

    // PC wrap on the full-ROM instance starting at FE.
    rom[8'hFE] = 8'h86; rom[8'hFF] = 8'hAA; rom[0] = 8'h01;
    pronta = 1'b1; desvio = 1'b0;
    do_reset();
    tick();
    chk("wrap_endereco1", endereco2, 8'hFF);
    tick();
    chk("wrap_valida", valida2, 1'b1);
    chk("wrap_opcode", opcode2, 8'h86);
    chk("wrap_operando", operando2, 8'hAA);
    chk("wrap_pc", ipc2, 8'hFE);
    chk("wrap_endereco2", endereco2, 8'h00);
    tick();
    chk("wrap_ack_valida", valida2, 1'b0);
    tick();
    chk("wrap_next_opcode", opcode2, 8'h01);
    chk("wrap_next_pc", ipc2, 8'h00);
    chk("wrap_erro", erro2, 1'b0);

    // Randomized program, stalls and redirects vs. instruction-stream walk.
    for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
    desvio = 1'b0; pronta = 1'b0;
    do_reset();
    exp_pc = 8'h00;
    hold = 1'b0;
    rnd_deliv = 0;
    h_op = 8'h00; h_oper = 8'h00; h_pc = 8'h00;
    for (int c = 0; c < 600; c++) begin
      if (hold) begin
        chk("rnd_hold_valida", valida, 1'b1);
        chk("rnd_hold_opcode", opcode, h_op);
        chk("rnd_hold_operando", operando, h_oper);
        chk("rnd_hold_pc", ipc, h_pc);
      end
      pronta = ($urandom_range(0, 2) != 0);
      desvio = ($urandom_range(0, 9) == 0) || (endereco >= 8'h70);
      alvo   = 8'($urandom_range(0, 8'h6F));
      if (valida === 1'b1 && pronta) begin
        e_op   = rom[exp_pc];
        e_oper = tem_operando(e_op) ? rom[8'(exp_pc + 8'd1)] : 8'h00;
        chk_instr("rnd", e_op, e_oper, exp_pc);
        exp_pc = exp_pc + (tem_operando(e_op) ? 8'd2 : 8'd1);
        rnd_deliv++;
      end
      if (desvio) exp_pc = alvo;
      hold   = (valida === 1'b1) && !pronta && !desvio;
      h_op   = opcode;
      h_oper = operando;
      h_pc   = ipc;
      tick();
    end
    chk("rnd_progress", rnd_deliv > 50, 1'b1);
    chk("rnd_erro", erro, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter TAM_ROM, default 128, number of valid program-ROM entries.
REQ-002 SHALL have parameter VETOR_RESET, default 8'h00, PC value loaded on reset.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have endereco  output  8  address to program ROM; combinational copy of the PC register.
REQ-006 SHALL have dado  input  8  ROM read data, valid combinationally in the same cycle as endereco.
REQ-007 SHALL have desvio  input  1  branch/redirect request from the control unit.
REQ-008 SHALL have desvio_alvo  input  8  redirect target address, sampled when desvio=1.
REQ-009 SHALL have instr_pronta  input  1  consumer ready to accept the delivered instruction.
REQ-010 SHALL have instr_valida  output  1  delivered instruction valid.
REQ-011 SHALL have instr_opcode  output  8  registered opcode byte.
REQ-012 SHALL have instr_operando  output  8  registered operand byte; 8'h00 for 1-byte instructions.
REQ-013 SHALL have instr_pc  output  8  address of the delivered opcode.
REQ-014 SHALL have erro_endereco  output  1  sticky flag: a fetch was attempted at pc >= TAM_ROM.

Function
REQ-015 SHALL implement FSM states BUSCA_OP, BUSCA_OPER, ENTREGA and PARADO.
REQ-016 SHALL classify an opcode as 1-byte when opcode[7:4] is 0, 1, 3, 4 or 5; all other opcodes are 2-byte (opcode + operand).
REQ-017 BUSCA_OP, pc < TAM_ROM: capture dado into the opcode register, record pc as instr_pc, pc <= pc+1, clear operand to 8'h00; go to ENTREGA if 1-byte, else to BUSCA_OPER.
REQ-018 BUSCA_OPER, pc < TAM_ROM: capture dado into the operand register, pc <= pc+1, go to ENTREGA.
REQ-019 ENTREGA: instr_valida=1; instr_opcode, instr_operando and instr_pc SHALL be held stable while instr_pronta=0.
REQ-020 ENTREGA with instr_pronta=1: the handshake completes that edge; go to BUSCA_OP.
REQ-021 Latency from entering BUSCA_OP to instr_valida=1 SHALL be 1 cycle for a 1-byte instruction and 2 cycles for a 2-byte instruction.
REQ-022 instr_valida SHALL be 0 in every state other than ENTREGA.
REQ-023 PC arithmetic SHALL be 8-bit modulo 256 (8'hFF+1 = 8'h00).
REQ-024 In BUSCA_OP or BUSCA_OPER with pc >= TAM_ROM: set erro_endereco, capture nothing, leave pc unchanged, go to PARADO.
REQ-025 PARADO SHALL be exited only by reset; desvio and instr_pronta are ignored there.
REQ-026 desvio=1 in BUSCA_OP, BUSCA_OPER or ENTREGA: pc <= desvio_alvo, go to BUSCA_OP, discard any partially fetched or undelivered instruction; instr_valida=0 on the following cycle.
REQ-027 desvio=1 has priority over every fetch action and over the pc >= TAM_ROM check in the same cycle.
REQ-028 desvio=1 together with instr_pronta=1 in ENTREGA: the current instruction counts as accepted, and the redirect still applies.
REQ-029 endereco SHALL equal pc in all states, including ENTREGA and PARADO.

Reset
REQ-030 On reset assertion, asynchronously: pc=VETOR_RESET, state=BUSCA_OP, instr_valida=0, instr_opcode=0, instr_operando=0, instr_pc=0, erro_endereco=0.
REQ-031 Reset asserted mid-fetch or mid-handshake SHALL abort the operation; the first fetch after release is at VETOR_RESET.
REQ-032 erro_endereco SHALL be cleared only by reset.

Verification
REQ-033 ROM[00..01]=86,AA; instr_pronta=1; release reset -> 2nd edge: instr_valida=1, opcode=86, operando=AA, instr_pc=00; endereco=02.
REQ-034 Same program, instr_pronta=0 for 5 cycles -> outputs hold 86/AA/00 and endereco=02 throughout; pronta=1 -> next fetch at 02 (96,E0).
REQ-035 ROM[00]=01 (1-byte) -> 1st edge: valid, opcode=01, operando=00; next fetch at 01.
REQ-036 ROM[04..05]=20,00; desvio=1, desvio_alvo=10 during BUSCA_OPER -> no delivery of opcode 20; next BUSCA_OP fetches at 10.
REQ-037 Opcode 86 at 7F, TAM_ROM=128 -> operand fetch at 80 sets erro_endereco, enters PARADO, instr_valida stays 0, desvio ignored; reset clears the flag and refetches at 00.
REQ-038 In ENTREGA, desvio=1, instr_pronta=1, alvo=20 -> next cycle instr_valida=0, endereco=20, the instruction is counted delivered once.
